// File: rtl/nmi_arb_pkg.sv
// Shared types, defaults and the round-robin pick function for the NMI arbiter.
package nmi_arb_pkg;

    typedef enum logic {IDLE, BUSY} arb_state_e;

    localparam logic [31:0] TO_RDATA_DEF = 32'hDEAD_BEEF;
    localparam int          MAX_MST      = 8;

    // Returns {found, idx}: first set req bit at or after ptr, wrapping at n.
    function automatic logic [3:0] rr_pick(input logic [MAX_MST-1:0] req,
                                           input logic [2:0]         ptr,
                                           input int                 n);
        logic [3:0] res;
        int         i;
        res = '0;
        for (int k = MAX_MST - 1; k >= 0; k--) begin
            i = (int'(ptr) + k) % n;
            if (k < n && req[3'(i)]) res = {1'b1, 3'(i)};
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first requester at or after ptr, with wrap.
module rr_arbiter
    import nmi_arb_pkg::*;
#(
    parameter int N    = 2,
    parameter int IW   = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any_o,
    output logic [IW-1:0] idx_o
);

    logic [3:0] pick;

    always_comb begin
        pick  = rr_pick(MAX_MST'(req), 3'(ptr), N);
        any_o = pick[3];
        idx_o = IW'(pick[2:0]);
    end

endmodule

// File: rtl/nmi_arbiter.sv
// Round-robin arbiter sharing one NMI slave port between NUM_MST masters,
// with a bus watchdog that terminates hung transfers and logs their address.
module nmi_arbiter
    import nmi_arb_pkg::*;
#(
    parameter int          NUM_MST     = 2,
    parameter int          TIMEOUT_CYC = 1024,
    parameter logic [31:0] TO_RDATA    = TO_RDATA_DEF,
    localparam int         IDX_W       = $clog2(NUM_MST)
) (
    input  logic                  clk_i,
    input  logic                  rst_n_i,
    input  logic [NUM_MST-1:0]    mst_valid_i,
    input  logic [NUM_MST*32-1:0] mst_addr_i,
    input  logic [NUM_MST*32-1:0] mst_wdata_i,
    input  logic [NUM_MST*4-1:0]  mst_wstrb_i,
    output logic [NUM_MST-1:0]    mst_ready_o,
    output logic [31:0]           mst_rdata_o,
    output logic                  slv_valid_o,
    output logic [31:0]           slv_addr_o,
    output logic [31:0]           slv_wdata_o,
    output logic [3:0]            slv_wstrb_o,
    input  logic                  slv_ready_i,
    input  logic [31:0]           slv_rdata_i,
    output logic                  to_flag_o,
    output logic [31:0]           to_addr_o,
    input  logic                  to_clr_i,
    output logic [IDX_W-1:0]      gnt_idx_o
);

    localparam int               CNT_W   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    localparam bit               TO_EN   = (TIMEOUT_CYC != 0);

    arb_state_e       state;
    logic [IDX_W-1:0] gnt, rr_ptr, req_idx, gnt_next;
    logic [CNT_W-1:0] to_cnt;
    logic             req_any, busy, gnt_valid, done, to_fire, abort;

    logic [NUM_MST-1:0][31:0] addr_a, wdata_a;
    logic [NUM_MST-1:0][3:0]  wstrb_a;

    assign addr_a  = mst_addr_i;
    assign wdata_a = mst_wdata_i;
    assign wstrb_a = mst_wstrb_i;

    rr_arbiter #(.N(NUM_MST)) u_rr (
        .req   (mst_valid_i),
        .ptr   (rr_ptr),
        .any_o (req_any),
        .idx_o (req_idx)
    );

    // Completion beats timeout; a master dropping valid aborts without a ready.
    always_comb begin
        busy      = (state == BUSY);
        gnt_valid = mst_valid_i[gnt];
        abort     = busy && !gnt_valid;
        done      = busy && gnt_valid && slv_ready_i;
        to_fire   = TO_EN && busy && gnt_valid && !slv_ready_i && (to_cnt == TO_LAST);
        gnt_next  = (gnt == IDX_W'(NUM_MST - 1)) ? '0 : gnt + 1'b1;

        slv_valid_o = busy && !to_fire;
        slv_addr_o  = busy ? addr_a[gnt]  : '0;
        slv_wdata_o = busy ? wdata_a[gnt] : '0;
        slv_wstrb_o = busy ? wstrb_a[gnt] : '0;

        mst_ready_o = (done || to_fire) ? (NUM_MST'(1) << gnt) : '0;
        mst_rdata_o = done ? slv_rdata_i : (to_fire ? TO_RDATA : '0);
        gnt_idx_o   = gnt;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state     <= IDLE;
            gnt       <= '0;
            rr_ptr    <= '0;
            to_cnt    <= '0;
            to_flag_o <= 1'b0;
            to_addr_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    to_cnt <= '0;
                    if (req_any) begin
                        gnt   <= req_idx;
                        state <= BUSY;
                    end
                end
                BUSY: begin
                    if (done || to_fire || abort) begin
                        state  <= IDLE;
                        rr_ptr <= gnt_next;
                        to_cnt <= '0;
                    end else begin
                        to_cnt <= to_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase

            if (to_fire) begin
                to_flag_o <= 1'b1;
                to_addr_o <= addr_a[gnt];
            end else if (to_clr_i) begin
                to_flag_o <= 1'b0;
            end
        end
    end

endmodule
